fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the write side of an asynchronous FIFO among `NUM_REQ` requesters. It runs entirely in the FIFO write-clock domain and drives the FIFO's `W_EN` and `DATA_IN`. It sinks the FIFO's `FULL` flag and grants the port in bounded bursts, so no requester can starve the others.

---
 rtl/fifo_wr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter sharing the write port of an asynchronous FIFO among
// NUM_REQ requesters. Runs entirely in the FIFO write-clock domain. A winner
// owns the port for at most BURST_LEN accepted words, then one IDLE cycle
// re-arbitrates starting just after the previous owner.
//
// Ports
//   CLK       in   write-domain clock (same as FIFO W_CLK)
//   RST_N     in   asynchronous active-low reset
//   REQ       in   [NUM_REQ]             per-requester word available
//   REQ_DATA  in   [NUM_REQ*DATA_WIDTH]  requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   FULL      in   FIFO full flag, used combinationally
//   ACK       out  [NUM_REQ]  one-hot, owner's word written this cycle
//   GNT       out  [NUM_REQ]  one-hot registered owner, zero when idle
//   BUSY      out  a grant is active
//   W_EN      out  FIFO write enable
//   DATA_IN   out  [DATA_WIDTH] FIFO write data
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic                          FULL,
  output logic [NUM_REQ-1:0]            ACK,
  output logic [NUM_REQ-1:0]            GNT,
  output logic                          BUSY,
  output logic                          W_EN,
  output logic [DATA_WIDTH-1:0]         DATA_IN
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   gnt_reg,   gnt_next;
  logic [CNT_W-1:0]     cnt_reg,   cnt_next;
  // Index of the most recent winner. While in GRANT it is also the current
  // owner, so no separate owner index register is needed.
  logic [IDX_W-1:0]     last_reg,  last_next;

  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
  logic [IDX_W-1:0]      cand_idx     [NUM_REQ];
  logic [IDX_W-1:0]      winner;
  logic                  owner_req;
  logic                  accept;

  // Unpack the flat requester data bus.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_data_arr[gi] = REQ_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Search order: cand_idx[k] = (last + 1 + k) mod NUM_REQ, so cand_idx[0]
  // is the requester right after the previous owner and the last entry is
  // the previous owner itself.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, last_reg} + (IDX_W + 1)'(gi + 1);
      assign cand_idx[gi] = (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W)
                                               : sum[IDX_W-1:0];
    end
  endgenerate

  // Walk from the back so the lowest search position with a set bit wins.
  always_comb begin
    winner = last_reg;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (REQ[cand_idx[k]]) begin
        winner = cand_idx[k];
      end
    end
  end

  assign owner_req = REQ[last_reg];
  assign accept    = (state_reg == GRANT) && owner_req && !FULL;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      cnt_reg   <= '0;
      last_reg  <= LAST_RST;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    unique case (state_reg)
      IDLE: begin
        if (|REQ) begin
          state_next       = GRANT;
          gnt_next         = '0;
          gnt_next[winner] = 1'b1;
          last_next        = winner;
          cnt_next         = '0;
        end
      end
      GRANT: begin
        // A withdraw wins over FULL: the owner has nothing to write, so
        // holding the port would only block the others.
        if (!owner_req) begin
          state_next = IDLE;
          gnt_next   = '0;
          cnt_next   = '0;
        end else if (accept) begin
          if (cnt_reg == CNT_LAST) begin
            state_next = IDLE;
            gnt_next   = '0;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        // FULL with the owner still requesting: hold everything.
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // Write-side outputs
  always_comb begin
    W_EN    = accept;
    ACK     = accept ? gnt_reg : '0;
    GNT     = gnt_reg;
    BUSY    = (state_reg == GRANT);
    DATA_IN = (state_reg == GRANT) ? req_data_arr[last_reg] : '0;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter. Requesters are modelled as
// word holders; the reference keeps only "who owns the port, how many words
// it has written, who was last" and derives the expected outputs each cycle.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int BL = 4;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [N-1:0]    REQ;
  logic [N*DW-1:0] REQ_DATA;
  logic            FULL;
  logic [N-1:0]    ACK;
  logic [N-1:0]    GNT;
  logic            BUSY;
  logic            W_EN;
  logic [DW-1:0]   DATA_IN;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .REQ     (REQ),
    .REQ_DATA(REQ_DATA),
    .FULL    (FULL),
    .ACK     (ACK),
    .GNT     (GNT),
    .BUSY    (BUSY),
    .W_EN    (W_EN),
    .DATA_IN (DATA_IN)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus state (what each requester currently presents)
  logic [N-1:0]  req_v;
  logic [DW-1:0] dat [N];
  logic          full_v;
  logic [N-1:0]  prev_ack;

  // Reference: owner (-1 = nobody), words written in this grant, last winner
  int m_owner;
  int m_cnt;
  int m_last;
  int wcount;

  task automatic model_reset();
    m_owner  = -1;
    m_cnt    = 0;
    m_last   = N - 1;
    prev_ack = '0;
  endtask

  task automatic apply_inputs();
    REQ  = req_v;
    FULL = full_v;
    for (int i = 0; i < N; i++) REQ_DATA[i*DW +: DW] = dat[i];
  endtask

  // Entered at posedge+1 with inputs applied; compares at posedge+3,
  // advances the reference, returns at the next posedge+1.
  task automatic cycle();
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    bit            busy;
    bit            acc;
    #2;
    busy = (m_owner >= 0);
    acc  = busy && req_v[m_owner] && !full_v;
    eg   = '0;
    ed   = '0;
    if (busy) begin
      eg[m_owner] = 1'b1;
      ed          = dat[m_owner];
    end
    check("gnt",     32'(GNT),     32'(eg));
    check("ack",     32'(ACK),     acc ? 32'(eg) : 32'd0);
    check("w_en",    32'(W_EN),    32'(acc));
    check("busy",    32'(BUSY),    32'(busy));
    check("data_in", 32'(DATA_IN), 32'(ed));
    if (W_EN) wcount++;
    prev_ack = acc ? eg : '0;
    if (!RST_N) begin
      model_reset();
    end else if (!busy) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && req_v[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_last  = m_owner;
          m_cnt   = 0;
        end
      end
    end else if (!req_v[m_owner]) begin
      m_owner = -1;
      m_cnt   = 0;
    end else if (acc) begin
      m_cnt++;
      if (m_cnt == BL) begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // Requesters in mask keep requesting and present a fresh word after ACK.
  task automatic hold(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (prev_ack[i]) dat[i] = DW'($urandom);
    end
    req_v  = mask;
    full_v = 1'b0;
    apply_inputs();
  endtask

  // Random requesters honouring the hold-until-ACK rule, with occasional
  // withdrawals and random FULL.
  task automatic gen_random(input bit rfull);
    for (int i = 0; i < N; i++) begin
      if (req_v[i] && prev_ack[i]) begin
        if ($urandom_range(3) == 0) req_v[i] = 1'b0;
        else dat[i] = DW'($urandom);
      end else if (req_v[i]) begin
        if ($urandom_range(15) == 0) req_v[i] = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        req_v[i] = 1'b1;
        dat[i]   = DW'($urandom);
      end
    end
    full_v = rfull && ($urandom_range(3) == 0);
    apply_inputs();
  endtask

  initial begin : main
    bit found;
    bit full_seq [9];

    RST_N  = 1'b0;
    req_v  = '1;
    full_v = 1'b0;
    for (int i = 0; i < N; i++) dat[i] = DW'($urandom);
    model_reset();
    apply_inputs();
    @(posedge CLK);
    #1;

    // 1: reset with all requesting, outputs stay idle
    repeat (3) cycle();
    $display("reset held 3 cycles with REQ=1111");

    // 1+3: release, first grant to requester 0, then round robin
    RST_N  = 1'b1;
    wcount = 0;
    hold('1);
    cycle();
    check("first_gnt", 32'(GNT), 32'd1);
    for (int c = 1; c < 25; c++) begin
      hold('1);
      cycle();
    end
    check("rr_writes", 32'(wcount), 32'd20);
    $display("round robin: %0d writes in 25 cycles", wcount);

    // 2: single requester, continuous
    repeat (2) begin hold('0); cycle(); end
    dat[0] = 4'hA;
    wcount = 0;
    repeat (12) begin
      req_v = 4'b0001; full_v = 1'b0; apply_inputs();
      cycle();
    end
    check("single_writes", 32'(wcount), 32'd9);
    $display("single requester: %0d writes in 12 cycles", wcount);

    // 4: FULL stall while requester 1 owns the port
    repeat (2) begin hold('0); cycle(); end
    full_seq = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    wcount   = 0;
    for (int c = 0; c < 9; c++) begin
      hold(4'b0010);
      full_v = full_seq[c];
      apply_inputs();
      cycle();
      if (c == 5) check("stall_gnt", 32'(GNT), 32'd2);
    end
    check("stall_writes", 32'(wcount), 32'd4);
    $display("full stall: %0d writes", wcount);

    // 6: asynchronous reset during the second word of a burst
    repeat (2) begin hold('0); cycle(); end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      hold('1);
      if (m_owner >= 0 && m_cnt == 1) found = 1'b1;
      else cycle();
    end
    check("rst_wait", 32'(found), 32'd1);
    #2;
    check("pre_rst_w_en", 32'(W_EN), 32'd1);
    RST_N = 1'b0;
    #1;
    check("rst_gnt",     32'(GNT),     32'd0);
    check("rst_w_en",    32'(W_EN),    32'd0);
    check("rst_ack",     32'(ACK),     32'd0);
    check("rst_busy",    32'(BUSY),    32'd0);
    check("rst_data_in", 32'(DATA_IN), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    hold('1);
    cycle();
    RST_N = 1'b1;
    $display("async reset mid-burst applied and released");

    // 5: withdraw after one word, then requester 1 is not skipped
    hold(4'b0101); cycle();
    check("wd_gnt0", 32'(GNT), 32'd1);
    hold(4'b0101); cycle();
    hold(4'b0100); cycle();
    hold(4'b0100); cycle();
    check("wd_gnt2", 32'(GNT), 32'd4);
    repeat (5) begin hold(4'b0110); cycle(); end
    check("wd_gnt1", 32'(GNT), 32'd2);
    $display("withdraw sequence done");

    // Random traffic with random FULL
    for (int c = 0; c < 1500; c++) begin
      gen_random(1'b1);
      cycle();
    end
    $display("random phase: 1500 cycles");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
